multiport_ram_nport: RTL

//  Parametrised N-port synchronous RAM; successor to the processor's fixed 2-port 12-bit data/instruction RAM.

---
 rtl/multiport_ram_nport.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/multiport_ram_nport.sv
// multiport_ram_nport
//   N-port synchronous RAM shared by the fetch and load/store units.
//   Every port can read and write in the same cycle. When several ports write
//   one address, the lowest port index wins. Reads are write-first and have a
//   latency of one cycle. Accesses outside MEM_DEPTH are flagged on addr_err.
//   A clear engine writes INIT_VALUE to every word, one word per cycle. It runs
//   after reset and whenever clear_req is pulsed.
//
//   Build option MPRAM_INIT_FILE_EN:
//     When defined, the array is preloaded at start-up and reset goes
//     straight to READY. clear_req can still start a sweep.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   addr       per-port address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata      per-port write data, packed the same way
//   we / re    per-port write / read enable
//   clear_req  single-cycle pulse that starts a clear sweep
//   rdata      per-port registered read data; holds its value when re=0
//   rvalid     per-port read-data-valid pulse
//   addr_err   per-port out-of-range pulse
//   collision  pulse: two or more ports wrote the same address
//   busy       clear sweep in progress
//
// state    | meaning
// ST_CLEAR | sweep writes INIT_VALUE to mem[cnt]; all port accesses ignored
// ST_READY | normal read/write service
module multiport_ram_nport #(
   parameter int MEM_DEPTH  = 4096,
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 12,
   parameter int PORT_COUNT = 2,
   parameter int INIT_VALUE = 0
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [PORT_COUNT*ADDR_WIDTH-1:0] addr,
   input  logic [PORT_COUNT*DATA_WIDTH-1:0] wdata,
   input  logic [PORT_COUNT-1:0]            we,
   input  logic [PORT_COUNT-1:0]            re,
   input  logic                             clear_req,
   output logic [PORT_COUNT*DATA_WIDTH-1:0] rdata,
   output logic [PORT_COUNT-1:0]            rvalid,
   output logic [PORT_COUNT-1:0]            addr_err,
   output logic                             collision,
   output logic                             busy
);

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   // One extra bit so that MEM_DEPTH == 2**ADDR_WIDTH can still be represented.
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
   localparam logic [DATA_WIDTH-1:0] INIT_WORD = DATA_WIDTH'(INIT_VALUE);

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

`ifdef MPRAM_INIT_FILE_EN
   localparam state_t RESET_STATE = ST_READY;
`else
   localparam state_t RESET_STATE = ST_CLEAR;
`endif

   state_t                          state_q, state_d;
   logic [ADDR_WIDTH-1:0]           cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]           mem_q [MEM_DEPTH];

   logic [PORT_COUNT*DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [PORT_COUNT-1:0]            rvalid_q, rvalid_d;
   logic [PORT_COUNT-1:0]            addr_err_q, addr_err_d;
   logic                             collision_q, collision_d;

   logic                             ready;
   logic [ADDR_WIDTH-1:0]            pa [PORT_COUNT];
   logic [DATA_WIDTH-1:0]            pw [PORT_COUNT];
   logic [PORT_COUNT-1:0]            in_range;
   logic [PORT_COUNT-1:0]            wr_en;
   logic [PORT_COUNT-1:0]            wr_keep;

`ifdef MPRAM_INIT_FILE_EN
   initial begin
      for (int i = 0; i < MEM_DEPTH; i++)
         mem_q[i] = INIT_WORD;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RESET_STATE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_READY;
               cnt_d   = '0;
            end
         end
         ST_READY: begin
            if (clear_req) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_READY;
      endcase
   end

   assign ready = (state_q == ST_READY);
   assign busy  = (state_q == ST_CLEAR);

   // Unpack the ports. A write is kept only if no lower-indexed port writes
   // the same address in this cycle.
   always_comb begin
      collision_d = 1'b0;
      for (int p = 0; p < PORT_COUNT; p++) begin
         pa[p]       = addr[p*ADDR_WIDTH +: ADDR_WIDTH];
         pw[p]       = wdata[p*DATA_WIDTH +: DATA_WIDTH];
         in_range[p] = ({1'b0, pa[p]} < DEPTH_EXT);
         wr_en[p]    = ready & we[p] & in_range[p];
      end
      wr_keep = wr_en;
      for (int p = 1; p < PORT_COUNT; p++) begin
         for (int q = 0; q < p; q++) begin
            if (wr_en[p] && wr_en[q] && (pa[p] == pa[q])) begin
               wr_keep[p]  = 1'b0;
               collision_d = 1'b1;
            end
         end
      end
   end

   // Read path. Writes in the same cycle are forwarded. The loop runs from the
   // highest port down to port 0, so the lowest-indexed writer has the last
   // word and therefore wins.
   always_comb begin
      rdata_d    = rdata_q;
      rvalid_d   = '0;
      addr_err_d = '0;
      for (int p = 0; p < PORT_COUNT; p++) begin
         addr_err_d[p] = ready & (we[p] | re[p]) & ~in_range[p];
         if (ready && re[p]) begin
            rvalid_d[p] = 1'b1;
            if (!in_range[p]) begin
               rdata_d[p*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else begin
               rdata_d[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[pa[p][IDX_W-1:0]];
               for (int q = PORT_COUNT - 1; q >= 0; q--) begin
                  if (wr_en[q] && (pa[q] == pa[p]))
                     rdata_d[p*DATA_WIDTH +: DATA_WIDTH] = pw[q];
               end
            end
         end
      end
   end

   // The array has no reset. Its contents survive reset until the sweep
   // overwrites them.
   always_ff @(posedge clk) begin
      if (state_q == ST_CLEAR) begin
         mem_q[cnt_q[IDX_W-1:0]] <= INIT_WORD;
      end else begin
         for (int p = 0; p < PORT_COUNT; p++) begin
            if (wr_keep[p])
               mem_q[pa[p][IDX_W-1:0]] <= pw[p];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q     <= '0;
         rvalid_q    <= '0;
         addr_err_q  <= '0;
         collision_q <= 1'b0;
      end else begin
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
         addr_err_q  <= addr_err_d;
         collision_q <= collision_d;
      end
   end

   assign rdata     = rdata_q;
   assign rvalid    = rvalid_q;
   assign addr_err  = addr_err_q;
   assign collision = collision_q;

endmodule
